// File: rtl/trace_pkg.sv
// Shared constants for the trace event path: event types, source codes,
// trace word field offsets and an event packing helper.
package trace_pkg;

    localparam logic [7:0] TRC_T_IDLE    = 8'h00;
    localparam logic [7:0] TRC_T_START   = 8'h01;
    localparam logic [7:0] TRC_T_STOP    = 8'h02;
    localparam logic [7:0] TRC_T_CMD     = 8'h03;
    localparam logic [7:0] TRC_T_STATUS  = 8'h04;
    localparam logic [7:0] TRC_T_ERROR   = 8'h05;
    localparam logic [7:0] TRC_T_IRQ     = 8'h06;
    localparam logic [7:0] TRC_T_DATA    = 8'h07;
    localparam logic [7:0] TRC_T_TRIGGER = 8'h0F;

    localparam logic [7:0] TRC_S_SYSTEM  = 8'h00;
    localparam logic [7:0] TRC_S_USB     = 8'h01;
    localparam logic [7:0] TRC_S_FDC0    = 8'h02;
    localparam logic [7:0] TRC_S_FDC1    = 8'h03;
    localparam logic [7:0] TRC_S_HDD     = 8'h04;
    localparam logic [7:0] TRC_S_PLL     = 8'h05;
    localparam logic [7:0] TRC_S_DMA     = 8'h06;
    localparam logic [7:0] TRC_S_CPU     = 8'h07;
    localparam logic [7:0] TRC_S_TIMER   = 8'h08;
    localparam logic [7:0] TRC_S_DEBUG   = 8'h09;

    localparam int TRC_DATA_LSB = 0;
    localparam int TRC_SRC_LSB  = 32;
    localparam int TRC_TYPE_LSB = 40;
    localparam int TRC_TS_LSB   = 48;
    localparam int TRC_EVT_W    = 48;
    localparam int TRC_WORD_W   = 64;

    function automatic logic [TRC_EVT_W-1:0] trc_pack(
        input logic [7:0]  t,
        input logic [7:0]  s,
        input logic [31:0] d
    );
        return {t, s, d};
    endfunction

endpackage

// File: rtl/trace_evt_fifo.sv
// Per-source event FIFO. A push into a full FIFO is accepted only when the
// same cycle also pops it, so occupancy stays at full.
module trace_evt_fifo
    import trace_pkg::*;
#(
    parameter int AW = 2,
    parameter int W  = TRC_EVT_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int DEPTH = 1 << AW;

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_cnt;
    logic          w_do_push;
    logic          w_do_pop;

    assign full      = (r_cnt == (AW+1)'(DEPTH));
    assign empty     = (r_cnt == '0);
    assign w_do_pop  = pop & ~empty;
    assign w_do_push = push & (~full | w_do_pop);
    assign dout      = r_mem[r_rptr];

    // Pointer and occupancy tracking; clear flushes without touching storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else if (clear) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + 1'b1;
            if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // Storage array; contents behind the read pointer are don't-care.
    always_ff @(posedge clk) begin
        if (w_do_push && !clear) r_mem[r_wptr] <= din;
    end

endmodule

// File: rtl/trace_event_mux.sv
// Trace front end: per-source FIFOs, round-robin arbiter, drop counting.
// Optional drop marker word enabled by `TRACE_DROP_MARKER_EN.
module trace_event_mux
    import trace_pkg::*;
#(
    parameter int NUM_SRC = 4,
    parameter int FIFO_AW = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  clear,
    input  logic [NUM_SRC-1:0]    src_valid,
    input  logic [8*NUM_SRC-1:0]  src_type,
    input  logic [8*NUM_SRC-1:0]  src_id,
    input  logic [32*NUM_SRC-1:0] src_data,
    output logic [63:0]           trace_data,
    output logic                  trace_write,
    output logic [NUM_SRC-1:0]    src_full,
    output logic [15:0]           drop_count,
    output logic                  overflow
);

    logic [NUM_SRC-1:0]   w_push;
    logic [NUM_SRC-1:0]   w_drop;
    logic [NUM_SRC-1:0]   w_pop;
    logic [NUM_SRC-1:0]   w_full;
    logic [NUM_SRC-1:0]   w_empty;
    logic [TRC_EVT_W-1:0] w_fdin  [NUM_SRC];
    logic [TRC_EVT_W-1:0] w_fdout [NUM_SRC];
    logic [TRC_EVT_W-1:0] w_sel;

    logic [2:0]  r_rr;
    logic [2:0]  w_hi;
    logic [2:0]  w_lo;
    logic        w_hi_vld;
    logic        w_lo_vld;
    logic [2:0]  w_gnt;
    logic        w_gnt_vld;
    logic [2:0]  w_rr_nxt;

    logic [3:0]  w_ndrop;
    logic [16:0] w_dsum;
    logic [15:0] r_drop_cnt;
    logic        r_ovf;
    logic [63:0] r_tdata;
    logic        r_twrite;

    logic                 w_mk_gnt;
    logic [TRC_EVT_W-1:0] w_mk_word;

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
        assign w_push[g] = src_valid[g] & enable & ~clear
                         & (src_type[8*g +: 8] != TRC_T_IDLE);
        assign w_drop[g] = w_push[g] & w_full[g] & ~w_pop[g];
        assign w_pop[g]  = w_gnt_vld & ~w_mk_gnt & (w_gnt == 3'(g));
        assign w_fdin[g] = trc_pack(src_type[8*g +: 8],
                                    src_id[8*g +: 8],
                                    src_data[32*g +: 32]);

        trace_evt_fifo #(
            .AW (FIFO_AW),
            .W  (TRC_EVT_W)
        ) u_fifo (
            .clk   (clk),
            .rst_n (rst_n),
            .clear (clear),
            .push  (w_push[g] & ~w_drop[g]),
            .pop   (w_pop[g]),
            .din   (w_fdin[g]),
            .dout  (w_fdout[g]),
            .full  (w_full[g]),
            .empty (w_empty[g])
        );
    end

    // Round robin: lowest non-empty source at/after the pointer, else wrap.
    always_comb begin
        w_hi_vld = 1'b0;
        w_hi     = '0;
        w_lo_vld = 1'b0;
        w_lo     = '0;
        for (int s = NUM_SRC - 1; s >= 0; s--) begin
            if (!w_empty[s]) begin
                w_lo_vld = 1'b1;
                w_lo     = 3'(s);
                if (3'(s) >= r_rr) begin
                    w_hi_vld = 1'b1;
                    w_hi     = 3'(s);
                end
            end
        end
    end

    assign w_gnt     = w_hi_vld ? w_hi : w_lo;
    assign w_gnt_vld = w_lo_vld;
    assign w_rr_nxt  = (w_gnt == 3'(NUM_SRC - 1)) ? 3'd0 : w_gnt + 3'd1;

    // Head entry of the popped FIFO and the number of drops this cycle.
    always_comb begin
        w_sel   = '0;
        w_ndrop = '0;
        for (int s = 0; s < NUM_SRC; s++) begin
            if (w_pop[s]) w_sel = w_fdout[s];
            w_ndrop = w_ndrop + {3'b000, w_drop[s]};
        end
    end

    assign w_dsum = {1'b0, r_drop_cnt} + {13'd0, w_ndrop};

`ifdef TRACE_DROP_MARKER_EN
    logic        r_mk_pend;
    logic [7:0]  r_mk_map;
    logic [15:0] r_mk_delta;
    logic [7:0]  w_dmap;
    logic [16:0] w_mk_sum;

    assign w_dmap    = 8'(w_drop);
    assign w_mk_sum  = {1'b0, r_mk_delta} + {13'd0, w_ndrop};
    assign w_mk_gnt  = r_mk_pend;
    assign w_mk_word = trc_pack(TRC_T_ERROR, TRC_S_DEBUG,
                                {r_mk_map, 8'h00, r_mk_delta});

    // Marker bookkeeping; emission restarts accumulation from this cycle's drops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mk_pend  <= 1'b0;
            r_mk_map   <= '0;
            r_mk_delta <= '0;
        end else if (clear) begin
            r_mk_pend  <= 1'b0;
            r_mk_map   <= '0;
            r_mk_delta <= '0;
        end else if (r_mk_pend) begin
            r_mk_pend  <= |w_drop;
            r_mk_map   <= w_dmap;
            r_mk_delta <= {12'd0, w_ndrop};
        end else if (|w_drop) begin
            r_mk_pend  <= 1'b1;
            r_mk_map   <= r_mk_map | w_dmap;
            r_mk_delta <= w_mk_sum[16] ? 16'hFFFF : w_mk_sum[15:0];
        end
    end
`else
    assign w_mk_gnt  = 1'b0;
    assign w_mk_word = '0;
`endif

    // Output word register and round-robin pointer update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tdata  <= '0;
            r_twrite <= 1'b0;
            r_rr     <= '0;
        end else if (clear) begin
            r_tdata  <= '0;
            r_twrite <= 1'b0;
            r_rr     <= '0;
        end else if (w_mk_gnt) begin
            r_tdata  <= {16'h0000, w_mk_word};
            r_twrite <= 1'b1;
        end else if (w_gnt_vld) begin
            r_tdata  <= {16'h0000, w_sel};
            r_twrite <= 1'b1;
            r_rr     <= w_rr_nxt;
        end else begin
            r_twrite <= 1'b0;
        end
    end

    // Saturating drop counter and sticky overflow flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_drop_cnt <= '0;
            r_ovf      <= 1'b0;
        end else if (clear) begin
            r_drop_cnt <= '0;
            r_ovf      <= 1'b0;
        end else if (|w_drop) begin
            r_drop_cnt <= w_dsum[16] ? 16'hFFFF : w_dsum[15:0];
            r_ovf      <= 1'b1;
        end
    end

    assign trace_data  = r_tdata;
    assign trace_write = r_twrite;
    assign src_full    = w_full;
    assign drop_count  = r_drop_cnt;
    assign overflow    = r_ovf;

endmodule
